// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: shared definitions for the APB timer slave.
//   - register word offsets (paddr[4:2])
//   - CTRL / STATUS bit positions
//   - default ID register value
//   - APB phase FSM state encoding
package apb_timer_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_ID     = 3'd4;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_AR_BIT     = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;
  localparam int unsigned CTRL_PS_LSB     = 8;
  localparam int unsigned CTRL_PS_MSB     = 15;

  localparam int unsigned STATUS_EXPIRED_BIT = 0;
  localparam int unsigned STATUS_PERR_BIT    = 1;

  localparam logic [31:0] TIMER_ID_DEFAULT = 32'h544D_0001;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_timer_prescaler.sv
// apb_timer_prescaler: 8-bit prescale counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : counter runs while high, held at 0 while low
//   clr        : synchronous clear (restarts the prescale period)
//   prescale   : terminal value; a tick is issued every prescale+1 cycles
//   tick       : combinational, high in the cycle the counter equals prescale
module apb_timer_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en || clr) begin
      cnt_d = '0;
    end else if (cnt_q == prescale) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB timer peripheral behind the AHB-to-APB bridge.
//   Hclk, Hresetn : clock, asynchronous active-low reset
//   psel          : bridge slave-select code (selected when == SEL_ID)
//   penable       : APB access phase
//   pwrite        : 1 = write, 0 = read
//   paddr         : address, paddr[4:2] selects the register
//   pwdata        : write data
//   prdata        : registered read data, loaded at the end of read setup
//   irq           : registered STATUS.EXPIRED & CTRL.IRQ_EN
// Registers: CTRL, LOAD, COUNT (RO), STATUS (W1C), ID (RO).
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter logic [2:0]  SEL_ID   = 3'b001,
  parameter logic [31:0] TIMER_ID = TIMER_ID_DEFAULT
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        irq
);

  apb_state_e  state_q, state_d;
  logic        ctrl_en_q, ctrl_en_d;
  logic        ctrl_ar_q, ctrl_ar_d;
  logic        ctrl_irq_en_q, ctrl_irq_en_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        expired_q, expired_d;
  logic        perr_q, perr_d;
  logic [31:0] prdata_q, prdata_d;
  logic        irq_q, irq_d;

  logic        sel, setup_ph, access_ph;
  logic        wr_en, rd_en, perr_evt;
  logic [2:0]  addr;
  logic        wr_ctrl, wr_load, wr_status;
  logic [31:0] rdata;
  logic        ps_clr, tick, expire;

  // Only paddr[4:2] is decoded.
  logic unused_paddr;
  assign unused_paddr = ^{paddr[31:5], paddr[1:0]};

  assign prdata = prdata_q;
  assign irq    = irq_q;

  // APB phase tracking
  always_comb begin
    sel       = (psel == SEL_ID);
    setup_ph  = sel & ~penable;
    access_ph = sel & penable;
    state_d   = APB_IDLE;
    wr_en     = 1'b0;
    perr_evt  = 1'b0;
    unique case (state_q)
      APB_IDLE: begin
        if (setup_ph)       state_d = APB_SETUP;
        else if (access_ph) perr_evt = 1'b1;
      end
      APB_SETUP: begin
        if (access_ph) begin
          state_d = APB_ACCESS;
          wr_en   = pwrite;
        end
      end
      APB_ACCESS: begin
        if (setup_ph)       state_d = APB_SETUP;
        else if (access_ph) perr_evt = 1'b1;
      end
      default: state_d = APB_IDLE;
    endcase
    rd_en     = setup_ph & ~pwrite;
    addr      = paddr[4:2];
    wr_ctrl   = wr_en & (addr == OFF_CTRL);
    wr_load   = wr_en & (addr == OFF_LOAD);
    wr_status = wr_en & (addr == OFF_STATUS);
  end

  // Read mux
  always_comb begin
    rdata = '0;
    unique case (addr)
      OFF_CTRL: begin
        rdata[CTRL_EN_BIT]                 = ctrl_en_q;
        rdata[CTRL_AR_BIT]                 = ctrl_ar_q;
        rdata[CTRL_IRQ_EN_BIT]             = ctrl_irq_en_q;
        rdata[CTRL_PS_MSB:CTRL_PS_LSB]     = prescale_q;
      end
      OFF_LOAD:  rdata = load_q;
      OFF_COUNT: rdata = count_q;
      OFF_STATUS: begin
        rdata[STATUS_EXPIRED_BIT] = expired_q;
        rdata[STATUS_PERR_BIT]    = perr_q;
      end
      OFF_ID:    rdata = TIMER_ID;
      default:   rdata = '0;
    endcase
  end

  // Prescale period restarts on a LOAD write or a PRESCALE change.
  assign ps_clr = wr_load |
                  (wr_ctrl & (pwdata[CTRL_PS_MSB:CTRL_PS_LSB] != prescale_q));

  apb_timer_prescaler u_prescaler (
    .clk      (Hclk),
    .rst_n    (Hresetn),
    .en       (ctrl_en_q),
    .clr      (ps_clr),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // Register bank and down-counter
  always_comb begin
    ctrl_en_d     = ctrl_en_q;
    ctrl_ar_d     = ctrl_ar_q;
    ctrl_irq_en_d = ctrl_irq_en_q;
    prescale_d    = prescale_q;
    load_d        = load_q;
    count_d       = count_q;
    expired_d     = expired_q;
    perr_d        = perr_q;
    prdata_d      = prdata_q;

    if (wr_ctrl) begin
      ctrl_en_d     = pwdata[CTRL_EN_BIT];
      ctrl_ar_d     = pwdata[CTRL_AR_BIT];
      ctrl_irq_en_d = pwdata[CTRL_IRQ_EN_BIT];
      prescale_d    = pwdata[CTRL_PS_MSB:CTRL_PS_LSB];
    end
    if (wr_load) load_d = pwdata;

    // A LOAD write overrides any tick in the same cycle.
    expire = tick & ~wr_load & (count_q == 32'd1);
    if (wr_load) begin
      count_d = pwdata;
    end else if (tick && (count_q > 32'd1)) begin
      count_d = count_q - 32'd1;
    end else if (expire) begin
      count_d = ctrl_ar_q ? load_q : '0;
    end

    // Clear first so a same-cycle set wins.
    if (wr_status && pwdata[STATUS_EXPIRED_BIT]) expired_d = 1'b0;
    if (expire)                                  expired_d = 1'b1;
    if (wr_status && pwdata[STATUS_PERR_BIT])    perr_d    = 1'b0;
    if (perr_evt)                                perr_d    = 1'b1;

    if (rd_en) prdata_d = rdata;

    // Built from next-state values so irq rises with EXPIRED.
    irq_d = expired_d & ctrl_irq_en_d;
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q       <= APB_IDLE;
      ctrl_en_q     <= 1'b0;
      ctrl_ar_q     <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      prescale_q    <= '0;
      load_q        <= '0;
      count_q       <= '0;
      expired_q     <= 1'b0;
      perr_q        <= 1'b0;
      prdata_q      <= '0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctrl_en_q     <= ctrl_en_d;
      ctrl_ar_q     <= ctrl_ar_d;
      ctrl_irq_en_q <= ctrl_irq_en_d;
      prescale_q    <= prescale_d;
      load_q        <= load_d;
      count_q       <= count_d;
      expired_q     <= expired_d;
      perr_q        <= perr_d;
      prdata_q      <= prdata_d;
      irq_q         <= irq_d;
    end
  end

endmodule

// File: tb/tb_apb_timer_slave.sv
// tb_apb_timer_slave: directed self-checking bench for apb_timer_slave.
module tb_apb_timer_slave;

  localparam logic [2:0] SEL = 3'b001;

  logic        Hclk;
  logic        Hresetn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  apb_timer_slave #(
    .SEL_ID   (SEL),
    .TIMER_ID (32'h544D_0001)
  ) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .irq     (irq)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Setup edge, then access edge commits the write; returns 1ns after commit.
  task automatic apb_write(input logic [2:0] code, input logic [2:0] off, input logic [31:0] d);
    @(posedge Hclk); #1;
    psel = code; penable = 1'b0; pwrite = 1'b1;
    paddr = {27'd0, off, 2'd0}; pwdata = d;
    @(posedge Hclk); #1;
    penable = 1'b1;
    @(posedge Hclk); #1;
    psel = 3'd0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] off, output logic [31:0] data);
    @(posedge Hclk); #1;
    psel = SEL; penable = 1'b0; pwrite = 1'b0;
    paddr = {27'd0, off, 2'd0};
    @(posedge Hclk); #1;
    data = prdata;
    penable = 1'b1;
    @(posedge Hclk); #1;
    psel = 3'd0; penable = 1'b0;
  endtask

  initial begin
    Hresetn = 1'b0;
    psel = 3'd0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;

    // Reset and ID read
    repeat (3) @(posedge Hclk);
    #1;
    check("rst_prdata", prdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_count", dut.count_q, 32'h0);
    Hresetn = 1'b1;
    apb_read(3'd4, rd);  check("id_read", rd, 32'h544D_0001);
    apb_read(3'd2, rd);  check("count_after_rst", rd, 32'h0);

    // One-shot expiry, PRESCALE = 0
    apb_write(SEL, 3'd1, 32'd3);
    apb_read(3'd2, rd);  check("count_loaded", rd, 32'd3);
    apb_write(SEL, 3'd0, 32'h0000_0005);
    for (int i = 1; i <= 3; i++) begin
      @(posedge Hclk); #1;
      check("oneshot_count", dut.count_q, 32'(3 - i));
      check("oneshot_irq", {31'd0, irq}, (i == 3) ? 32'd1 : 32'd0);
    end
    repeat (4) @(posedge Hclk);
    #1;
    check("oneshot_hold_count", dut.count_q, 32'd0);
    check("oneshot_hold_irq", {31'd0, irq}, 32'd1);
    apb_read(3'd3, rd);  check("oneshot_status", rd, 32'h1);
    apb_write(SEL, 3'd3, 32'h1);
    check("w1c_irq_low", {31'd0, irq}, 32'd0);
    apb_read(3'd3, rd);  check("w1c_status", rd, 32'h0);

    // Auto-reload, PRESCALE = 3: COUNT 2,1,2,... changing every 4 cycles
    apb_write(SEL, 3'd0, 32'h0);
    apb_write(SEL, 3'd1, 32'd2);
    apb_write(SEL, 3'd0, 32'h0000_0303);
    check("ar_count_k0", dut.count_q, 32'd2);
    for (int k = 1; k <= 16; k++) begin
      @(posedge Hclk); #1;
      check("ar_count", dut.count_q, (((k / 4) % 2) == 0) ? 32'd2 : 32'd1);
      check("ar_irq_off", {31'd0, irq}, 32'd0);
    end
    apb_read(3'd0, rd);  check("ctrl_readback", rd, 32'h0000_0303);

    // W1C collides with the expiry 24 edges after enable
    // (the read above consumed k17..k19; wait to k21)
    repeat (2) @(posedge Hclk);
    #1;
    apb_write(SEL, 3'd3, 32'h1);
    check("collide_count_reloaded", dut.count_q, 32'd2);
    apb_read(3'd3, rd);  check("collide_status", rd, 32'h1);

    apb_write(SEL, 3'd0, 32'h0);
    apb_write(SEL, 3'd3, 32'h1);
    apb_read(3'd3, rd);  check("later_w1c_status", rd, 32'h0);
    check("later_w1c_irq", {31'd0, irq}, 32'd0);
    apb_read(3'd2, rd);  check("frozen_count", rd, 32'd1);

    // Protocol error: access phase without setup
    @(posedge Hclk); #1;
    psel = SEL; penable = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'd5;
    @(posedge Hclk); #1;
    psel = 3'd0; penable = 1'b0; pwrite = 1'b0;
    apb_read(3'd1, rd);  check("perr_load_unchanged", rd, 32'd2);
    apb_read(3'd3, rd);  check("perr_status", rd, 32'h2);
    apb_read(3'd2, rd);  check("perr_count_unchanged", rd, 32'd1);
    apb_write(SEL, 3'd3, 32'h2);
    apb_read(3'd3, rd);  check("perr_cleared", rd, 32'h0);

    // Wrong psel code
    apb_write(3'b010, 3'd1, 32'd7);
    apb_read(3'd1, rd);  check("wrong_psel_load", rd, 32'd2);

    // Reserved CTRL bits and unmapped offsets read 0
    apb_write(SEL, 3'd0, 32'hFFFF_00F8);
    apb_read(3'd0, rd);  check("ctrl_reserved", rd, 32'h0);
    apb_read(3'd5, rd);  check("offset5_zero", rd, 32'h0);
    apb_write(SEL, 3'd4, 32'hDEAD_BEEF);
    apb_read(3'd4, rd);  check("id_readonly", rd, 32'h544D_0001);

    // Reset mid-count
    apb_write(SEL, 3'd1, 32'd100);
    apb_write(SEL, 3'd0, 32'h0000_FF05);
    apb_read(3'd2, rd);  check("count_100", rd, 32'd100);
    repeat (5) @(posedge Hclk);
    #3;
    check("pre_rst_count", dut.count_q, 32'd100);
    Hresetn = 1'b0;
    #1;
    check("async_rst_prdata", prdata, 32'h0);
    check("async_rst_irq", {31'd0, irq}, 32'h0);
    check("async_rst_count", dut.count_q, 32'h0);
    #10;
    Hresetn = 1'b1;
    repeat (20) @(posedge Hclk);
    #1;
    check("post_rst_count", dut.count_q, 32'h0);
    check("post_rst_irq", {31'd0, irq}, 32'h0);
    apb_read(3'd0, rd);  check("post_rst_ctrl", rd, 32'h0);
    apb_read(3'd1, rd);  check("post_rst_load", rd, 32'h0);
    apb_read(3'd2, rd);  check("post_rst_count_rd", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_timer_slave.md
# apb_timer_slave

APB peripheral sitting directly downstream of the AHB-to-APB bridge, on one of its three `psel` decode slots. Decodes the bridge's APB transfers (`psel`/`penable`/`pwrite`/`paddr`/`pwdata`), holds a small register bank, and runs a prescaled 32-bit down-counter with optional auto-reload and an interrupt. Returns read data on `prdata` to the bridge's `prdata` input.

## Interface

Parameters:
- `SEL_ID`, 3'b001: `psel` code that selects this slave.
- `TIMER_ID`, 32'h544D_0001: constant returned by the ID register.

Ports:
- `Hclk`  in  1  single clock.
- `Hresetn`  in  1  asynchronous, active-low reset.
- `psel`  in  3  bridge slave-select code; this slave is selected when `psel == SEL_ID`.
- `penable`  in  1  APB access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  32  address; only `paddr[4:2]` is decoded.
- `pwdata`  in  32  write data.
- `prdata`  out  32  registered read data.
- `irq`  out  1  registered, `STATUS.EXPIRED & CTRL.IRQ_EN`.

## Operation

Register map (word offset `paddr[4:2]`):
- 0 CTRL, R/W:
  - bit0 EN.
  - bit1 AUTO_RELOAD.
  - bit2 IRQ_EN.
  - [15:8] PRESCALE.
  - Other bits read 0.
- 1 LOAD, R/W: 32 bits. A write also loads COUNT.
- 2 COUNT, RO: current count. Writes are ignored.
- 3 STATUS, W1C:
  - bit0 EXPIRED.
  - bit1 PERR.
- 4 ID, RO: returns `TIMER_ID`.
- 5–7: read 0; writes ignored.

APB phase FSM: states IDLE, SETUP, ACCESS.
- IDLE → SETUP when `sel & !penable`, where `sel = (psel == SEL_ID)`.
- SETUP → ACCESS when `sel & penable`. SETUP → IDLE otherwise.
- ACCESS → SETUP when `sel & !penable`. ACCESS → IDLE otherwise.
- `sel & penable` seen in IDLE or ACCESS (no preceding setup phase) is a protocol error:
  - The transfer is ignored.
  - PERR is set.
  - The state stays IDLE / goes IDLE.

Writes:
- Committed on the clock edge that ends a legal access phase (state SETUP, `sel & penable & pwrite`).

Reads:
- `prdata` is loaded on the edge that ends the setup phase (`sel & !penable & !pwrite`) with the read-mux value.
- It is therefore stable throughout the access phase.
- It holds its value until the next read setup.

Prescaler and counter:
- An 8-bit prescale counter runs while EN = 1. It issues `tick` when it equals PRESCALE, then returns to 0.
- PRESCALE = 0 gives a tick every cycle. PRESCALE = N gives one tick every N+1 cycles.
- On `tick` with COUNT > 1: COUNT decrements by 1.
- On `tick` with COUNT == 1:
  - EXPIRED is set.
  - COUNT ← LOAD if AUTO_RELOAD, otherwise 0.
- COUNT == 0: the counter is stopped and no further expiry occurs.
- EN = 0: COUNT freezes and the prescale counter is held at 0.
- Arithmetic is unsigned 32-bit. The counter never underflows below 0.

Simultaneous events:
- LOAD write in the same cycle as a tick: the write wins. COUNT ← `pwdata` and the prescale counter clears.
- STATUS W1C in the same cycle as an expiry: the set wins, and EXPIRED stays 1.
- CTRL write changing PRESCALE: the prescale counter clears.

## Timing

Reset: all registers, `prdata`, `irq`, COUNT and the prescale counter are 0, and the FSM is in IDLE. Reset takes effect immediately and asynchronously, including mid-transfer; the interrupted transfer has no effect.

Cycle-level behaviour:
- Read latency: data is valid one cycle after the setup edge, i.e. during the access phase. No wait states.
- Write effect: visible in register reads from the cycle after the access edge.
- LOAD write: COUNT = LOAD in the following cycle. The first decrement occurs PRESCALE+1 cycles later (if EN = 1).
- Expiry timing: EXPIRED rises LOAD × (PRESCALE+1) enabled cycles after the load, and `irq` rises in the same cycle.

## Structure

Shared package `apb_timer_pkg`:
- Register offsets.
- CTRL/STATUS bit positions.
- Default ID constant.
- APB FSM state enum.

Sub-module `apb_timer_prescaler`: 8-bit prescale counter with enable and clear inputs and a `tick` output. The top level holds the FSM, register bank, read mux and down-counter.

## Test plan

- **Reset and ID read.** Assert reset, then read offset 4 → `prdata` = 32'h544D_0001; COUNT = 0 and `irq` = 0.
- **One-shot expiry.** Write LOAD = 3, CTRL = 32'h0000_0005 (EN, IRQ_EN, PRESCALE = 0) → EXPIRED and `irq` rise after 3 cycles; COUNT = 0 and stays 0.
- **Auto-reload with prescale.** LOAD = 2, CTRL = 32'h0000_0303 (EN, AUTO_RELOAD, PRESCALE = 3) → COUNT sequence 2, 1, 2, … changes every 4 cycles; EXPIRED every 8 cycles.
- **W1C collision.** Write STATUS = 1 in the exact cycle of an expiry → EXPIRED remains 1. A later write of STATUS = 1 → EXPIRED = 0 and `irq` = 0.
- **Protocol error.** Drive `psel = SEL_ID`, `penable = 1` with no setup phase, `pwrite = 1`, `paddr` offset 1, `pwdata = 5` → LOAD unchanged and PERR = 1. A transfer with a wrong `psel` code → no register change.
- **Reset mid-count.** Assert `Hresetn` low while COUNT = 100 → all outputs are 0 immediately and COUNT does not resume.
